// File: rtl/vminmax_reduce.sv
// vminmax_reduce: multi-beat vector min/max reduction (vredmin[u]/vredmax[u]).
// Stage 1 reduces one beat to a candidate; stage 2 folds candidates into a seeded accumulator.
module vminmax_reduce #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [MASK_WIDTH-1:0] in_mask,
  input  logic [DATA_WIDTH-1:0] in_seed,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [SEW_WIDTH-1:0]  in_sew,
  input  logic                  in_signed,
  input  logic                  in_max,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  // Keys are 65-bit two's complement so signed and unsigned 64-bit elements share one comparator.
  localparam int KeyW   = 65;
  localparam int Slots  = DATA_WIDTH / 8;
  localparam int Levels = $clog2(Slots);
  localparam int TreeN  = 1 << Levels;

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  function automatic logic [1:0] clamp_sew(input logic [SEW_WIDTH-1:0] s);
    int unsigned v;
    v = 32'(s);
    return (v > 32'd3) ? 2'd3 : 2'(v);
  endfunction

  function automatic logic [KeyW-1:0] extend(input logic [63:0] v, input logic [1:0] sew,
                                             input logic sgn);
    logic [KeyW-1:0] k;
    unique case (sew)
      2'd0:    k = {{57{sgn & v[7]}}, v[7:0]};
      2'd1:    k = {{49{sgn & v[15]}}, v[15:0]};
      2'd2:    k = {{33{sgn & v[31]}}, v[31:0]};
      default: k = {sgn & v[63], v};
    endcase
    return k;
  endfunction

  function automatic logic better(input logic [KeyW-1:0] a, input logic [KeyW-1:0] b,
                                  input logic mx);
    return mx ? ($signed(a) > $signed(b)) : ($signed(a) < $signed(b));
  endfunction

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    logic [63:0] m;
    unique case (sew)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

  state_e state_q, state_d;

  logic [1:0]            sew_q;
  logic                  signed_q, max_q;
  logic [1:0]            cur_sew;
  logic                  cur_signed, cur_max;
  logic                  idle, accept, take;

  logic                  s1_valid_q, s1_first_q, s1_any_q;
  logic [KeyW-1:0]       s1_cand_q, seed_q;
  logic [KeyW-1:0]       acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  assign idle     = (state_q == StIdle);
  assign in_ready = idle | (state_q == StAccum);
  assign accept   = in_valid & in_ready;
  // A beat arriving in idle without in_first is dropped.
  assign take     = accept & (in_first | ~idle);

  // The first beat uses the live config; later beats use what it latched.
  assign cur_sew    = idle ? clamp_sew(in_sew) : sew_q;
  assign cur_signed = idle ? in_signed : signed_q;
  assign cur_max    = idle ? in_max : max_q;

  if (DATA_WIDTH > 64) begin : g_wide
    logic unused_seed;
    assign unused_seed = ^in_seed[DATA_WIDTH-1:64];
  end

  // Stage 1: unpack elements into tree leaves
  logic [KeyW-1:0] leaf_key [TreeN];
  logic            leaf_act [TreeN];

  always_comb begin
    for (int i = 0; i < TreeN; i++) begin
      leaf_key[i] = '0;
      leaf_act[i] = 1'b0;
    end
    unique case (cur_sew)
      2'd0: begin
        for (int j = 0; j < DATA_WIDTH / 8; j++) begin
          leaf_key[j] = extend(64'(in_data[j*8 +: 8]), 2'd0, cur_signed);
          leaf_act[j] = in_mask[j];
        end
      end
      2'd1: begin
        for (int j = 0; j < DATA_WIDTH / 16; j++) begin
          leaf_key[j] = extend(64'(in_data[j*16 +: 16]), 2'd1, cur_signed);
          leaf_act[j] = in_mask[j];
        end
      end
      2'd2: begin
        for (int j = 0; j < DATA_WIDTH / 32; j++) begin
          leaf_key[j] = extend(64'(in_data[j*32 +: 32]), 2'd2, cur_signed);
          leaf_act[j] = in_mask[j];
        end
      end
      default: begin
        for (int j = 0; j < DATA_WIDTH / 64; j++) begin
          leaf_key[j] = extend(in_data[j*64 +: 64], 2'd3, cur_signed);
          leaf_act[j] = in_mask[j];
        end
      end
    endcase
  end

  // Pairwise reduction tree; a node takes the upper child only when it is strictly better.
  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    localparam int N = TreeN >> (l + 1);
    logic [KeyW-1:0] k [N];
    logic            a [N];
    for (genvar i = 0; i < N; i++) begin : g_node
      logic [KeyW-1:0] lo_k, hi_k;
      logic            lo_a, hi_a, pick_hi;
      if (l == 0) begin : g_leaf
        assign lo_k = leaf_key[2*i];
        assign hi_k = leaf_key[2*i+1];
        assign lo_a = leaf_act[2*i];
        assign hi_a = leaf_act[2*i+1];
      end else begin : g_inner
        assign lo_k = g_lvl[l-1].k[2*i];
        assign hi_k = g_lvl[l-1].k[2*i+1];
        assign lo_a = g_lvl[l-1].a[2*i];
        assign hi_a = g_lvl[l-1].a[2*i+1];
      end
      assign pick_hi = hi_a & (~lo_a | better(hi_k, lo_k, cur_max));
      assign k[i]    = pick_hi ? hi_k : lo_k;
      assign a[i]    = lo_a | hi_a;
    end
  end

  logic [KeyW-1:0] root_key;
  logic            root_act;
  assign root_key = g_lvl[Levels-1].k[0];
  assign root_act = g_lvl[Levels-1].a[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_any_q   <= 1'b0;
      s1_cand_q  <= '0;
      seed_q     <= '0;
      sew_q      <= '0;
      signed_q   <= 1'b0;
      max_q      <= 1'b0;
    end else begin
      s1_valid_q <= take;
      if (take) begin
        s1_first_q <= idle;
        s1_any_q   <= root_act;
        s1_cand_q  <= root_key;
      end
      if (take && idle) begin
        seed_q   <= extend(in_seed[63:0], cur_sew, cur_signed);
        sew_q    <= cur_sew;
        signed_q <= cur_signed;
        max_q    <= cur_max;
      end
    end
  end

  // Stage 2: seed on the first candidate, ties keep the accumulator.
  always_comb begin
    logic [KeyW-1:0] base;
    base  = s1_first_q ? seed_q : acc_q;
    acc_d = acc_q;
    if (s1_valid_q) begin
      acc_d = (s1_any_q && better(s1_cand_q, base, max_q)) ? s1_cand_q : base;
    end
  end

  // Drain waits for stage 1 to empty so the result register sees the final accumulator.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (take) state_d = in_last ? StDrain : StAccum;
      end
      StAccum: begin
        if (accept && in_last) state_d = StDrain;
      end
      StDrain: begin
        if (!s1_valid_q) begin
          state_d    = StHold;
          out_data_d = DATA_WIDTH'(acc_q[63:0] & sew_mask(sew_q));
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_vminmax_reduce.sv
// Scoreboarded bench for vminmax_reduce: directed cases then randomized reductions
// against an arithmetic reference model.
module tb_vminmax_reduce;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_mask = '0;
  logic [63:0] in_seed = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_sew = '0;
  logic        in_signed = 1'b0;
  logic        in_max = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  bit          rand_rdy = 1'b0;
  bit          force_rdy = 1'b1;

  vminmax_reduce #(
    .DATA_WIDTH(64),
    .SEW_WIDTH (2),
    .MASK_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_seed  (in_seed),
    .in_first (in_first),
    .in_last  (in_last),
    .in_sew   (in_sew),
    .in_signed(in_signed),
    .in_max   (in_max),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    check(name, 64'(got), 64'(exp));
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks stability while stalled.
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %h, expected no result", out_data);
        end else begin
          check("result", out_data, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Reference model: elements as plain integers, seed first, strictly-better replaces.
  function automatic logic [63:0] lowmask(input int bits);
    return (bits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
  endfunction

  function automatic logic signed [65:0] to_num(input logic [63:0] raw, input int bits,
                                                input bit sg);
    logic [63:0]        v;
    logic signed [65:0] n;
    v = raw & lowmask(bits);
    n = $signed({2'b00, v});
    if (sg && v[bits-1]) n = n - (66'sd1 <<< bits);
    return n;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] m, input logic [63:0] s,
                           input bit f, input bit l, input logic [1:0] sw, input bit sg,
                           input bit mx, output int waits);
    bit ok;
    in_data = d; in_mask = m; in_seed = s; in_first = f; in_last = l;
    in_sew = sw; in_signed = sg; in_max = mx; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      waits++;
      if (waits > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL accept_timeout: got in_ready low for %0d cycles, expected acceptance", waits);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_red(input logic [63:0] dq[$], input logic [7:0] mq[$],
                         input logic [63:0] seed, input logic [1:0] sw, input bit sg,
                         input bit mx, input bit gaps, output int tail_waits);
    int                 bits, n, w;
    logic signed [65:0] best, x;
    logic [63:0]        best_raw, raw;
    bits     = 8 << sw;
    n        = 64 / bits;
    best     = to_num(seed, bits, sg);
    best_raw = seed & lowmask(bits);
    foreach (dq[b]) begin
      for (int e = 0; e < n; e++) begin
        if (mq[b][e]) begin
          raw = (dq[b] >> (e * bits)) & lowmask(bits);
          x   = to_num(raw, bits, sg);
          if (mx ? (x > best) : (x < best)) begin
            best     = x;
            best_raw = raw;
          end
        end
      end
    end
    exp_q.push_back(best_raw);
    tail_waits = 0;
    foreach (dq[b]) begin
      bit l;
      l = (b == dq.size() - 1);
      if (b == 0) begin
        send_beat(dq[b], mq[b], seed, 1'b1, l, sw, sg, mx, w);
      end else begin
        // Later beats carry junk config/seed and a stray in_first now and then.
        send_beat(dq[b], mq[b], {$urandom, $urandom}, ($urandom_range(0, 7) == 0), l,
                  2'($urandom), 1'($urandom), 1'($urandom), w);
        tail_waits += w;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 500) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int          w;
    logic [63:0] dq[$];
    logic [7:0]  mq[$];
    logic [63:0] bd;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);
    chk1("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: SEW=8 signed max, single beat, latency
    dq.delete(); mq.delete();
    dq.push_back(64'h807F_01FF_0010_2030); mq.push_back(8'hFF);
    run_red(dq, mq, 64'h00, 2'd0, 1'b1, 1'b1, 1'b0, w);
    @(negedge clk);
    chk1("t1_ready_low", in_ready, 1'b0);
    chk1("t1_valid_t0", out_valid, 1'b0);
    @(negedge clk);
    chk1("t1_valid_t1", out_valid, 1'b0);
    @(negedge clk);
    chk1("t1_valid_t2", out_valid, 1'b1);
    wait_idle();

    // 2: unsigned min with seed FF, signed min with seed 00
    run_red(dq, mq, 64'hFF, 2'd0, 1'b0, 1'b0, 1'b0, w);
    wait_idle();
    run_red(dq, mq, 64'h00, 2'd0, 1'b1, 1'b0, 1'b0, w);
    wait_idle();

    // 3: SEW=32 signed min, three back-to-back beats, -5 in beat 2 lane 1
    dq.delete(); mq.delete();
    dq.push_back(64'h0000_0007_0000_0064); mq.push_back(8'hFF);
    dq.push_back(64'hFFFF_FFFB_0000_0003); mq.push_back(8'hFF);
    dq.push_back(64'h0000_0001_FFFF_FFFF); mq.push_back(8'hFF);
    run_red(dq, mq, 64'h0, 2'd2, 1'b1, 1'b0, 1'b0, w);
    check("t3_no_stall", 64'(w), 64'd0);
    @(negedge clk);
    chk1("t3_ready_low", in_ready, 1'b0);
    wait_idle();

    // 4: SEW=16 max, all lanes masked, seed survives
    dq.delete(); mq.delete();
    dq.push_back({$urandom, $urandom}); mq.push_back(8'h00);
    dq.push_back({$urandom, $urandom}); mq.push_back(8'h00);
    run_red(dq, mq, 64'hABCD_0000_0000_1234, 2'd1, 1'b0, 1'b1, 1'b0, w);
    wait_idle();

    // 5: output back-pressure; a new first beat waits for the handshake
    force_rdy = 1'b0;
    @(posedge clk);
    #1;
    dq.delete(); mq.delete();
    dq.push_back({$urandom, $urandom}); mq.push_back(8'h5A);
    run_red(dq, mq, {$urandom, $urandom}, 2'd0, 1'b0, 1'b1, 1'b0, w);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk1("t5_valid_up", out_valid, 1'b1);
    bd = {$urandom, $urandom};
    in_data = bd; in_mask = 8'hFF; in_seed = 64'h0; in_first = 1'b1; in_last = 1'b1;
    in_sew = 2'd3; in_signed = 1'b1; in_max = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t5_ready_low", in_ready, 1'b0);
      chk1("t5_valid_held", out_valid, 1'b1);
    end
    force_rdy = 1'b1;
    dq.delete(); mq.delete();
    dq.push_back(bd); mq.push_back(8'hFF);
    run_red(dq, mq, 64'h0, 2'd3, 1'b1, 1'b0, 1'b0, w);
    w = 0;
    wait_idle();

    // 6: reset mid-reduction, then stray beat without in_first in idle
    send_beat({$urandom, $urandom}, 8'hFF, 64'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, w);
    send_beat({$urandom, $urandom}, 8'hFF, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, w);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk1("t6_rst_ready", in_ready, 1'b1);
    chk1("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dq.delete(); mq.delete();
    dq.push_back({$urandom, $urandom}); mq.push_back(8'hF0);
    run_red(dq, mq, {$urandom, $urandom}, 2'd0, 1'b1, 1'b1, 1'b0, w);
    wait_idle();
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 64'h0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, w);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("t6_no_result", out_valid, 1'b0);
    end

    // Randomized reductions with random output back-pressure
    rand_rdy = 1'b1;
    for (int r = 0; r < 150; r++) begin
      int nb;
      nb = $urandom_range(1, 4);
      dq.delete(); mq.delete();
      for (int b = 0; b < nb; b++) begin
        dq.push_back({$urandom, $urandom});
        mq.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
      end
      run_red(dq, mq, {$urandom, $urandom}, 2'($urandom), 1'($urandom), 1'($urandom), 1'b1, w);
    end
    wait_idle();
    rand_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
